serial_subtractor: RTL and testbench

Bit-serial, LSB-first subtractor computing `a - b` over WIDTH cycles with a single registered borrow, the inverse-direction companion of the full adder. Built around one 1-bit full-subtractor cell. It sits beside the adder datapath as a small-area arithmetic unit driven by a start/done handshake.

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int MIN_WIDTH = 2;

   // Bit counter only needs to reach WIDTH-1; keep at least one bit.
   function automatic int count_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (a - b) with start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int            CW   = count_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_reg;
   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] a_sr_reg;
   logic [WIDTH-1:0] b_sr_reg;
   logic [WIDTH-1:0] res_reg;
   logic             bor_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [WIDTH-1:0] diff_reg;
   logic             borrow_reg;
   logic             cell_d;
   logic             cell_bo;

   full_subtractor u_cell (
      .a    (a_sr_reg[0]),
      .b    (b_sr_reg[0]),
      .bin  (bor_reg),
      .diff (cell_d),
      .bout (cell_bo)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         a_sr_reg   <= '0;
         b_sr_reg   <= '0;
         res_reg    <= '0;
         bor_reg    <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         diff_reg   <= '0;
         borrow_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_sr_reg  <= a;
                  b_sr_reg  <= b;
                  bor_reg   <= 1'b0;
                  count_reg <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= SHIFT;
               end
            end
            SHIFT: begin
               // Result fills from the MSB so bit 0 lands at the LSB after WIDTH shifts.
               res_reg  <= {cell_d, res_reg[WIDTH-1:1]};
               a_sr_reg <= a_sr_reg >> 1;
               b_sr_reg <= b_sr_reg >> 1;
               bor_reg  <= cell_bo;
               if (count_reg == LAST) begin
                  state_reg <= DONE;
               end else begin
                  count_reg <= count_reg + CW'(1);
               end
            end
            DONE: begin
               diff_reg   <= res_reg;
               borrow_reg <= bor_reg;
               done_reg   <= 1'b1;
               busy_reg   <= 1'b0;
               state_reg  <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic ovf_bit_reg;
   logic ovf_reg;

   // Borrow into the MSB differing from borrow out of it flags signed overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_bit_reg <= 1'b0;
         ovf_reg     <= 1'b0;
      end else begin
         if (state_reg == SHIFT && count_reg == LAST) begin
            ovf_bit_reg <= bor_reg ^ cell_bo;
         end
         if (state_reg == DONE) begin
            ovf_reg <= ovf_bit_reg;
         end
      end
   end

   assign ovf = ovf_reg;
`endif

   assign busy   = busy_reg;
   assign done   = done_reg;
   assign diff   = diff_reg;
   assign borrow = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=3, plus the 1-bit cell.
// Build with SERIAL_SUB_OVF_EN defined to also check the overflow output.
module tb_serial_subtractor;

   typedef struct {
      logic [7:0] d;
      logic       bo;
      logic       ov;
      int         acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   exp_t q8[$];
   exp_t q3[$];

   logic       rst8 = 1'b1, start8 = 1'b0, busy8, done8, borrow8;
   logic [7:0] a8 = '0, b8 = '0, diff8;
   logic       rst3 = 1'b1, start3 = 1'b0, busy3, done3, borrow3;
   logic [2:0] a3 = '0, b3 = '0, diff3;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf8, ovf3;
`endif

   logic fa = 1'b0, fb = 1'b0, fbin = 1'b0, fdiff, fbout;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(ovf8)
`endif
   );

   serial_subtractor #(.WIDTH(3)) dut3 (
      .clk(clk), .rst(rst3), .start(start3), .a(a3), .b(b3),
      .busy(busy3), .done(done3), .diff(diff3), .borrow(borrow3)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(ovf3)
`endif
   );

   full_subtractor u_fs (.a(fa), .b(fb), .bin(fbin), .diff(fdiff), .bout(fbout));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // Reference values from plain integer arithmetic.
   function automatic exp_t model(input int av, input int bv, input int w, input int acc);
      exp_t e;
      int   m, r;
      m     = (1 << w) - 1;
      r     = (av - bv) & m;
      e.d   = 8'(r);
      e.bo  = (av < bv);
      e.ov  = (((av >> (w-1)) & 1) != ((bv >> (w-1)) & 1)) &&
              (((r >> (w-1)) & 1) != ((av >> (w-1)) & 1));
      e.acc = acc;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (done8) begin
         if (q8.size() == 0) begin
            check_eq("done8_unexpected", 32'(done8), 32'd0);
         end else begin
            e = q8.pop_front();
            $display("w8 op: diff=%02h borrow=%b (exp %02h/%b) at cycle %0d", diff8, borrow8, e.d, e.bo, cyc);
            check_eq("diff8", 32'(diff8), 32'(e.d));
            check_eq("borrow8", 32'(borrow8), 32'(e.bo));
            check_eq("latency8", 32'(cyc - e.acc), 32'd9);
`ifdef SERIAL_SUB_OVF_EN
            check_eq("ovf8", 32'(ovf8), 32'(e.ov));
`endif
         end
      end
      if (done3) begin
         if (q3.size() == 0) begin
            check_eq("done3_unexpected", 32'(done3), 32'd0);
         end else begin
            e = q3.pop_front();
            $display("w3 op: diff=%0d borrow=%b (exp %0d/%b) at cycle %0d", diff3, borrow3, e.d, e.bo, cyc);
            check_eq("diff3", 32'(diff3), 32'(e.d));
            check_eq("borrow3", 32'(borrow3), 32'(e.bo));
            check_eq("latency3", 32'(cyc - e.acc), 32'd4);
`ifdef SERIAL_SUB_OVF_EN
            check_eq("ovf3", 32'(ovf3), 32'(e.ov));
`endif
         end
      end
   end

   // Called at a negedge; returns at the negedge where done8 is seen.
   // glitch_at > 0 re-asserts start with other operands that many cycles in.
   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input int glitch_at);
      int k;
      check_eq("idle_busy8", 32'(busy8), 32'd0);
      a8 = av;  b8 = bv;  start8 = 1'b1;
      q8.push_back(model(av, bv, 8, cyc + 1));
      @(negedge clk);
      start8 = 1'b0;
      k = 0;
      while (!done8 && k < 20) begin
         check_eq("busy8", 32'(busy8), 32'd1);
         @(negedge clk);
         k++;
         if (k == glitch_at) begin
            start8 = 1'b1;  a8 = 8'h55;  b8 = 8'hAA;
         end else begin
            start8 = 1'b0;
         end
      end
      check_eq("done8_seen", 32'(done8), 32'd1);
      check_eq("busy8_at_done", 32'(busy8), 32'd0);
   endtask

   int prev_acc3 = -1;
   task automatic op3(input logic [2:0] av, input logic [2:0] bv);
      int k;
      if (prev_acc3 >= 0) check_eq("gap3", 32'(cyc + 1 - prev_acc3), 32'd5);
      prev_acc3 = cyc + 1;
      a3 = av;  b3 = bv;  start3 = 1'b1;
      q3.push_back(model(int'(av), int'(bv), 3, cyc + 1));
      @(negedge clk);
      start3 = 1'b0;
      k = 0;
      while (!done3 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_eq("done3_seen", 32'(done3), 32'd1);
   endtask

   initial begin
      // 1-bit cell, all input combinations
      for (int i = 0; i < 8; i++) begin
         int r;
         {fa, fb, fbin} = 3'(i);
         #1;
         r = int'(fa) - int'(fb) - int'(fbin);
         check_eq("fs_diff", 32'(fdiff), 32'(r & 1));
         check_eq("fs_bout", 32'(fbout), 32'(r < 0));
      end

      repeat (3) @(negedge clk);
      check_eq("rst_busy8", 32'(busy8), 32'd0);
      check_eq("rst_done8", 32'(done8), 32'd0);
      check_eq("rst_diff8", 32'(diff8), 32'd0);
      check_eq("rst_borrow8", 32'(borrow8), 32'd0);
      check_eq("rst_busy3", 32'(busy3), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check_eq("rst_ovf8", 32'(ovf8), 32'd0);
`endif
      rst8 = 1'b0;  rst3 = 1'b0;
      @(negedge clk);

      op8(8'd5, 8'd3, 0);
      @(negedge clk);
      op8(8'd3, 8'd5, 0);
      @(negedge clk);
      op8(8'd0, 8'd0, 0);
      op8(8'h80, 8'h01, 0);
      op8(8'h7F, 8'hFF, 0);
      op8(8'h10, 8'h01, 0);
      op8(8'hC8, 8'h37, 0);

      // Start during SHIFT is dropped; back-to-back start right after done is taken.
      op8(8'h21, 8'h09, 4);
      op8(8'h09, 8'h21, 0);

      // Reset mid-operation aborts with no done.
      @(negedge clk);
      a8 = 8'h44;  b8 = 8'h11;  start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst8 = 1'b1;
      @(negedge clk);
      rst8 = 1'b0;
      check_eq("midrst_busy8", 32'(busy8), 32'd0);
      check_eq("midrst_done8", 32'(done8), 32'd0);
      check_eq("midrst_diff8", 32'(diff8), 32'd0);
      check_eq("midrst_borrow8", 32'(borrow8), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check_eq("midrst_ovf8", 32'(ovf8), 32'd0);
`endif
      repeat (12) @(negedge clk);
      op8(8'hFF, 8'h01, 0);

      // rst and start together: start is dropped.
      @(negedge clk);
      rst8 = 1'b1;  start8 = 1'b1;  a8 = 8'h12;  b8 = 8'h34;
      @(negedge clk);
      rst8 = 1'b0;  start8 = 1'b0;
      check_eq("rststart_busy8", 32'(busy8), 32'd0);
      @(negedge clk);
      check_eq("rststart_busy8_b", 32'(busy8), 32'd0);
      repeat (12) @(negedge clk);

      // WIDTH=3 exhaustive, back-to-back
      for (int x = 0; x < 8; x++) begin
         for (int y = 0; y < 8; y++) begin
            op3(3'(x), 3'(y));
         end
      end

      repeat (4) @(negedge clk);
      check_eq("q8_drained", 32'(q8.size()), 32'd0);
      check_eq("q3_drained", 32'(q3.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
